// File: rtl/uart_pkg.sv
// uart_pkg -- shared UART definitions, imported by the receiver and transmitter.
// Contents: receive FSM state encoding and the data-bits-per-frame constant.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if -- consumer-side bundle of the UART receiver.
// Signals: rx_data/rx_valid (FIFO head), rx_pop (consume head),
//          frame_err/overrun (sticky flags), err_clr (clear flags),
//          parity_err (sticky, only with UART_RX_PARITY_EN defined).
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_fifo_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] rx_data;
   logic                      rx_valid;
   logic                      rx_pop;
   logic                      frame_err;
   logic                      overrun;
   logic                      err_clr;
`ifdef UART_RX_PARITY_EN
   logic                      parity_err;
`endif

   modport master (
`ifdef UART_RX_PARITY_EN
      output parity_err,
`endif
      output rx_data, rx_valid, frame_err, overrun,
      input  rx_pop, err_clr
   );

   modport slave (
`ifdef UART_RX_PARITY_EN
      input  parity_err,
`endif
      input  rx_data, rx_valid, frame_err, overrun,
      output rx_pop, err_clr
   );

endinterface

// File: rtl/uart_rx_fifo_buf.sv
// uart_rx_fifo_buf -- receive FIFO, power-of-two depth, head shown combinationally.
// Ports: clk, reset_n (async active-low), push/push_data (write), pop/pop_data
//        (read head), full, empty, count.
// A pop while empty is ignored. A push while full is only accepted when a
// pop happens in the same cycle; otherwise the new byte is dropped.
module uart_rx_fifo_buf #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            count <= count + 1'b1;
         end else if (!push_ok && pop_ok) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- UART receiver (8N1) feeding a small receive FIFO.
// Ports: clk (system clock), reset_n (async active-low), uart_rx (serial in,
//        idle high, asynchronous), rx_if (master modport: rx_data, rx_valid,
//        rx_pop, frame_err, overrun, err_clr, and parity_err when enabled).
// Build option: define UART_RX_PARITY_EN to receive 8E1 frames; a parity
// mismatch discards the byte and sets the sticky parity_err flag.
//
// state  | meaning
// IDLE   | line idle, waiting for the first synchronized low sample
// START  | down-count to mid start bit; high there means glitch, back to IDLE
// DATA   | sample 8 data bits LSB first, one every CLKS_PER_BIT clocks
// PARITY | sample even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sample stop bit; after a low stop bit, hold until line is high
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 5000,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           uart_rx,
   uart_rx_fifo_if.master rx_if
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT/2 - 1);
   localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);

   localparam logic [2:0] ST_IDLE   = IDLE;
   localparam logic [2:0] ST_START  = START;
   localparam logic [2:0] ST_DATA   = DATA;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] ST_PARITY = PARITY;
`endif
   localparam logic [2:0] ST_STOP   = STOP;

   logic [1:0]                sync;
   logic                      rx_s;
   logic [2:0]                state;
   logic [CNT_W-1:0]          cnt;
   logic                      cnt_done;
   logic [2:0]                bit_idx;
   logic [UART_DATA_BITS-1:0] shreg;
   logic                      hold;
   logic                      stop_smp;
   logic                      push;
   logic                      frame_set;
   logic                      pop_ok;
   logic                      overrun_set;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
`ifdef UART_RX_PARITY_EN
   logic                      par_bad;
   logic                      parity_set;
`endif

   // Synchronizer flops reset high so the idle line is not seen as a start bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync <= 2'b11;
      end else begin
         sync <= {sync[0], uart_rx};
      end
   end

   assign rx_s     = sync[1];
   assign cnt_done = (cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         hold    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  state <= ST_START;
                  cnt   <= CNT_HALF;
               end
            end
            ST_START: begin
               if (!cnt_done) begin
                  cnt <= cnt - 1'b1;
               end else if (rx_s) begin
                  state <= ST_IDLE;
               end else begin
                  state   <= ST_DATA;
                  cnt     <= CNT_BIT;
                  bit_idx <= '0;
               end
            end
            ST_DATA: begin
               if (!cnt_done) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                  cnt   <= CNT_BIT;
                  if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state <= ST_PARITY;
`else
                     state <= ST_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (!cnt_done) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  par_bad <= parity_set;
                  state   <= ST_STOP;
                  cnt     <= CNT_BIT;
               end
            end
`endif
            ST_STOP: begin
               if (hold) begin
                  if (rx_s) begin
                     hold  <= 1'b0;
                     state <= ST_IDLE;
                  end
               end else if (!cnt_done) begin
                  cnt <= cnt - 1'b1;
               end else if (rx_s) begin
                  state <= ST_IDLE;
               end else begin
                  hold <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
               hold  <= 1'b0;
            end
         endcase
      end
   end

   // Push happens on the stop-sample cycle itself so the byte is visible
   // at the FIFO head on the very next clock.
   assign stop_smp  = (state == ST_STOP) && cnt_done && !hold;
   assign frame_set = stop_smp && !rx_s;
`ifdef UART_RX_PARITY_EN
   assign parity_set = (state == ST_PARITY) && cnt_done && (^{shreg, rx_s});
   assign push       = stop_smp && rx_s && !par_bad;
`else
   assign push       = stop_smp && rx_s;
`endif

   assign pop_ok      = rx_if.rx_pop && !fifo_empty;
   assign overrun_set = push && fifo_full && !pop_ok;

   uart_rx_fifo_buf #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (shreg),
      .pop       (rx_if.rx_pop),
      .pop_data  (rx_if.rx_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign rx_if.rx_valid = (fifo_count != '0);

   // A set in the same cycle as err_clr wins, so no event is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_if.frame_err  <= 1'b0;
         rx_if.overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         rx_if.parity_err <= 1'b0;
`endif
      end else begin
         rx_if.frame_err  <= frame_set   || (rx_if.frame_err  && !rx_if.err_clr);
         rx_if.overrun    <= overrun_set || (rx_if.overrun    && !rx_if.err_clr);
`ifdef UART_RX_PARITY_EN
         rx_if.parity_err <= parity_set  || (rx_if.parity_err && !rx_if.err_clr);
`endif
      end
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5000, meaning system clocks per bit (6 MHz / 1200 baud); legal range is 4 or more.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries; legal values are powers of two, 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on posedge clk.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port uart_rx, input, 1 bit: serial line, asynchronous to clk, idle high.
REQ-006 SHALL have port rx_data, output, 8 bits: byte at the FIFO head.
REQ-007 SHALL have port rx_valid, output, 1 bit: FIFO not empty.
REQ-008 SHALL have port rx_pop, input, 1 bit: consumer pops the head byte this cycle.
REQ-009 SHALL have port frame_err, output, 1 bit: sticky flag, stop bit sampled low.
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag, byte dropped because the FIFO was full.
REQ-011 SHALL have port err_clr, input, 1 bit: clears all sticky error flags.

Function
REQ-012 SHALL pass uart_rx through a 2-flop synchronizer before any use (2 clk latency).
REQ-013 SHALL run the FSM IDLE -> START -> DATA -> STOP -> IDLE, clocked by clk and paced by a bit counter; there is no derived clock.
REQ-014 SHALL leave IDLE on the first synchronized low sample and load the counter with CLKS_PER_BIT/2 - 1.
REQ-015 SHALL re-sample in START at the half-bit point; if the line is high again, the glitch is ignored and the FSM returns to IDLE with no flag set.
REQ-016 SHALL sample 8 data bits in DATA, LSB first, each exactly CLKS_PER_BIT clocks after the previous sample, using a 3-bit index.
REQ-017 SHALL sample the stop bit in STOP; if high, the byte is pushed to the FIFO; if low, frame_err is set, the byte is discarded and the FSM enters IDLE only after the line returns high.
REQ-018 SHALL present rx_data combinationally from the head entry; rx_valid = (count != 0).
REQ-019 SHALL ignore rx_pop while rx_valid is low, with no pointer change.
REQ-020 SHALL, on a push while full without a same-cycle pop, drop the new byte, set overrun and keep the FIFO contents unchanged.
REQ-021 SHALL, on a push and pop in the same cycle (including when full), accept both, leave count unchanged and report no overrun.
REQ-022 SHALL use pointers of width log2(FIFO_DEPTH) that wrap naturally and a count of width log2(FIFO_DEPTH)+1.
REQ-023 SHALL give err_clr priority below a same-cycle error set, so the flag remains 1.
REQ-024 SHALL have a latency of 1 clk from the stop-bit sample clock to rx_valid high.

Reset
REQ-025 SHALL, on reset_n low, asynchronously set FSM = IDLE, counters = 0, FIFO pointers/count = 0, both synchronizer flops = 1, rx_valid = 0, frame_err = 0 and overrun = 0 (plus parity_err = 0 if present).
REQ-026 SHALL make reset mid-frame abandon the partial byte; after release, reception resumes on the next falling edge.
REQ-027 SHALL define rx_data = 8'h00 during reset (head entry cleared).

Configuration
REQ-028 SHALL provide macro UART_RX_PARITY_EN: when defined, the FSM adds a PARITY state between DATA and STOP sampling an even-parity bit, a mismatch sets a sticky output parity_err (cleared by err_clr) and the byte is discarded; when undefined, there is no PARITY state, no parity_err port and frames are 8N1.

Structure
REQ-029 SHALL place the state enum uart_rx_state_t (IDLE, START, DATA, PARITY, STOP) and the constant UART_DATA_BITS = 8 in the shared package uart_pkg, which the existing transmitter also imports.
REQ-030 SHALL implement the FIFO as sub-module uart_rx_fifo_buf (push/pop/full/empty/count); the synchronizer and FSM stay in uart_rx_fifo.

Verification (CLKS_PER_BIT = 16, FIFO_DEPTH = 4)
REQ-031 SHALL cover: frame 8'hA5 at 16 clk/bit -> rx_valid rises 1 clk after the stop sample, rx_data = 8'hA5, no flags.
REQ-032 SHALL cover: low pulse of 5 clk on idle line -> no byte, no flags, FSM back to IDLE.
REQ-033 SHALL cover: frame 8'h3C with stop bit low -> frame_err = 1, rx_valid stays 0; then err_clr pulse -> frame_err = 0.
REQ-034 SHALL cover: 5 frames 8'h01..8'h05 with no pop -> pops return 01,02,03,04, overrun = 1, 8'h05 lost.
REQ-035 SHALL cover: FIFO full with rx_pop asserted on the push cycle of 8'h06 -> no overrun, count stays 4, head advances.
REQ-036 SHALL cover: reset_n low at data bit 4 of 8'hFF, then release and send 8'h81 -> only 8'h81 received.
